mux_scan_ctrl: RTL

- Sequencer that sits directly upstream of the 4:1 case-statement mux (MuxCase).
- Drives the mux `select` input through every channel in turn and holds each channel for a programmable dwell time.
- Samples the single-bit mux output at the end of each dwell and assembles the samples into a parallel result word.
- Uses a start/busy/done handshake so that a controller or bench can request one full scan of all channels.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/MuxCase.sv | 19 +
 rtl/mux_scan_dwell_cnt.sv | 29 ++
 rtl/mux_scan_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared state encoding and default sizing for the mux scan sequencer.
package mux_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_DWELL  = 2;

endpackage

// File: rtl/MuxCase.sv
// 4:1 combinational mux driven by the scan sequencer; data_out = data_in[select].
module MuxCase (
  input  logic [3:0] data_in,
  input  logic [1:0] select,
  output logic       data_out
);

  always_comb begin
    data_out = 1'b0;
    case (select)
      2'd0: data_out = data_in[0];
      2'd1: data_out = data_in[1];
      2'd2: data_out = data_in[2];
      2'd3: data_out = data_in[3];
      default: data_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_scan_dwell_cnt.sv
// Modulo-DWELL counter; wrap marks the last cycle of a dwell while enabled.
module mux_scan_dwell_cnt #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int             CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  assign wrap = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || wrap) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, samples each after DWELL cycles
// and publishes the word with a done pulse. MUX_SCAN_CONT_EN adds gapless continuous scanning.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int DWELL  = DEF_DWELL
) (
`ifdef MUX_SCAN_CONT_EN
  input  logic              cont,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  select,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] result
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ch;
  logic [SEL_W-1:0]   r_select;
  logic               r_busy;
  logic               r_done;
  logic [NUM_CH-1:0]  r_shadow;
  logic [NUM_CH-1:0]  r_result;
  logic [NUM_CH-1:0]  w_shadow_next;
  logic [NUM_CH-1:0]  w_capture;
  logic               w_wrap;
  logic               w_last;
  logic               w_cont;

`ifdef MUX_SCAN_CONT_EN
  assign w_cont = cont;
`else
  assign w_cont = 1'b0;
`endif

  assign w_last = w_wrap && (r_ch == LAST_CH);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (r_state == ST_IDLE),
    .enable (r_state == ST_SCAN),
    .wrap   (w_wrap)
  );

  // The final channel goes straight into result from mux_out, bypassing the shadow.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bit
    assign w_shadow_next[gi] = (w_wrap && (r_ch == SEL_W'(gi))) ? mux_out : r_shadow[gi];
    assign w_capture[gi]     = (gi == NUM_CH - 1) ? mux_out : r_shadow[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ch     <= '0;
      r_select <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_shadow <= '0;
      r_result <= '0;
    end else begin
      r_done   <= 1'b0;
      r_shadow <= w_shadow_next;
      case (r_state)
        ST_IDLE: begin
          r_select <= '0;
          r_busy   <= 1'b0;
          if (start) begin
            r_state <= ST_SCAN;
            r_ch    <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_wrap) begin
            if (!w_last) begin
              r_ch     <= r_ch + 1'b1;
              r_select <= r_ch + 1'b1;
            end else begin
              r_result <= w_capture;
              r_done   <= 1'b1;
              r_ch     <= '0;
              r_select <= '0;
              if (!w_cont) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign select = r_select;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
